// File: rtl/psa_loader.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : psa_loader
// Description : Host byte-stream loader for the PSA pattern BRAM and the
//               search-block BRAM. Parses CMD/ADDR/LEN/DATA frames, drives
//               the BRAM port-A write strobes and publishes the p/pl/b/bl
//               descriptors consumed by the search engine.
//               Optional macro LOADER_CSUM_EN appends an XOR checksum byte
//               to every frame.
// Revision    : 1.0 - initial release
// ============================================================================
module psa_loader #(
    parameter logic [7:0] CMD_PAT = 8'h50,
    parameter logic [7:0] CMD_BLK = 8'h42
) (
    input  logic       CLK100MHZ,
    input  logic       reset,
    input  logic [7:0] in_byte,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic       lock,
    output logic       wea_p,
    output logic [7:0] addra_p,
    output logic [7:0] dina_p,
    output logic       wea,
    output logic [7:0] addra,
    output logic [7:0] dina,
    output logic [7:0] p,
    output logic [7:0] pl,
    output logic [7:0] b,
    output logic [7:0] bl,
    output logic       busy,
    output logic       loaded,
    output logic       err
);

    localparam logic [2:0] c_st_idle = 3'd0;
    localparam logic [2:0] c_st_addr = 3'd1;
    localparam logic [2:0] c_st_len  = 3'd2;
    localparam logic [2:0] c_st_data = 3'd3;
    localparam logic [2:0] c_st_csum = 3'd4;
    localparam logic [2:0] c_st_fin  = 3'd5;

    logic [2:0] r_state;
    logic       r_tgt_pat;   // 1: pattern BRAM, 0: block BRAM
    logic [7:0] r_start;
    logic [7:0] r_len;
    logic [7:0] r_ptr;
    logic [7:0] r_cnt;       // data bytes still to come
    logic       r_wea_p;
    logic [7:0] r_addra_p;
    logic [7:0] r_dina_p;
    logic       r_wea;
    logic [7:0] r_addra;
    logic [7:0] r_dina;
    logic [7:0] r_p;
    logic [7:0] r_pl;
    logic [7:0] r_b;
    logic [7:0] r_bl;
    logic       r_loaded;
    logic       r_err;
`ifdef LOADER_CSUM_EN
    logic [7:0] r_sum;
`endif

    logic w_ready;
    logic w_acc;

    // lock only gates the start of a frame; FIN is a one-cycle bubble
    always_comb begin
        w_ready = 1'b1;
        if (r_state == c_st_idle) begin
            w_ready = ~lock;
        end else if (r_state == c_st_fin) begin
            w_ready = 1'b0;
        end
        w_acc = in_valid & w_ready;
    end

    // Frame parser, registered BRAM write strobes and descriptor update
    always_ff @(posedge CLK100MHZ) begin
        if (reset) begin
            r_state   <= c_st_idle;
            r_tgt_pat <= 1'b0;
            r_start   <= 8'd0;
            r_len     <= 8'd0;
            r_ptr     <= 8'd0;
            r_cnt     <= 8'd0;
            r_wea_p   <= 1'b0;
            r_addra_p <= 8'd0;
            r_dina_p  <= 8'd0;
            r_wea     <= 1'b0;
            r_addra   <= 8'd0;
            r_dina    <= 8'd0;
            r_p       <= 8'd0;
            r_pl      <= 8'd0;
            r_b       <= 8'd0;
            r_bl      <= 8'd0;
            r_loaded  <= 1'b0;
            r_err     <= 1'b0;
`ifdef LOADER_CSUM_EN
            r_sum     <= 8'd0;
`endif
        end else begin
            r_wea_p  <= 1'b0;
            r_wea    <= 1'b0;
            r_loaded <= 1'b0;
            r_err    <= 1'b0;
            case (r_state)
                c_st_idle: begin
                    if (w_acc) begin
                        if ((in_byte == CMD_PAT) || (in_byte == CMD_BLK)) begin
                            r_tgt_pat <= (in_byte == CMD_PAT);
                            r_state   <= c_st_addr;
`ifdef LOADER_CSUM_EN
                            r_sum     <= 8'd0;
`endif
                        end else begin
                            r_err <= 1'b1;
                        end
                    end
                end
                c_st_addr: begin
                    if (w_acc) begin
                        r_start <= in_byte;
                        r_ptr   <= in_byte;
                        r_state <= c_st_len;
                    end
                end
                c_st_len: begin
                    if (w_acc) begin
                        if (in_byte == 8'd0) begin
                            r_err   <= 1'b1;
                            r_state <= c_st_idle;
                        end else begin
                            r_len   <= in_byte;
                            r_cnt   <= in_byte;
                            r_state <= c_st_data;
                        end
                    end
                end
                c_st_data: begin
                    if (w_acc) begin
                        if (r_tgt_pat) begin
                            r_wea_p   <= 1'b1;
                            r_addra_p <= r_ptr;
                            r_dina_p  <= in_byte;
                        end else begin
                            r_wea   <= 1'b1;
                            r_addra <= r_ptr;
                            r_dina  <= in_byte;
                        end
                        // 8-bit pointer wraps naturally from 8'hFF to 8'h00
                        r_ptr <= r_ptr + 8'd1;
                        r_cnt <= r_cnt - 8'd1;
`ifdef LOADER_CSUM_EN
                        r_sum <= r_sum ^ in_byte;
                        if (r_cnt == 8'd1) begin
                            r_state <= c_st_csum;
                        end
`else
                        if (r_cnt == 8'd1) begin
                            r_state <= c_st_fin;
                        end
`endif
                    end
                end
`ifdef LOADER_CSUM_EN
                c_st_csum: begin
                    if (w_acc) begin
                        if (in_byte == r_sum) begin
                            r_state <= c_st_fin;
                        end else begin
                            // written data is not rolled back, descriptors keep old values
                            r_err   <= 1'b1;
                            r_state <= c_st_idle;
                        end
                    end
                end
`endif
                c_st_fin: begin
                    r_loaded <= 1'b1;
                    if (r_tgt_pat) begin
                        r_p  <= r_start;
                        r_pl <= r_len;
                    end else begin
                        r_b  <= r_start;
                        r_bl <= r_len;
                    end
                    r_state <= c_st_idle;
                end
                default: begin
                    r_state <= c_st_idle;
                end
            endcase
        end
    end

    assign in_ready = w_ready;
    assign wea_p    = r_wea_p;
    assign addra_p  = r_addra_p;
    assign dina_p   = r_dina_p;
    assign wea      = r_wea;
    assign addra    = r_addra;
    assign dina     = r_dina;
    assign p        = r_p;
    assign pl       = r_pl;
    assign b        = r_b;
    assign bl       = r_bl;
    assign busy     = (r_state != c_st_idle);
    assign loaded   = r_loaded;
    assign err      = r_err;

endmodule
`default_nettype wire

// File: tb/tb_psa_loader.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_psa_loader
// Description : Self-checking bench for psa_loader. A frame-level model
//               tracks bytes received per frame and predicts strobes and
//               descriptors; directed streams exercise the main cases.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_psa_loader;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] in_byte = 8'd0;
    logic       in_valid = 1'b0;
    logic       lock = 1'b0;
    logic       in_ready;
    logic       wea_p, wea, busy, loaded, err;
    logic [7:0] addra_p, dina_p, addra, dina, p, pl, b, bl;

    psa_loader dut (
        .CLK100MHZ(clk), .reset(reset), .in_byte(in_byte), .in_valid(in_valid),
        .in_ready(in_ready), .lock(lock), .wea_p(wea_p), .addra_p(addra_p),
        .dina_p(dina_p), .wea(wea), .addra(addra), .dina(dina), .p(p), .pl(pl),
        .b(b), .bl(bl), .busy(busy), .loaded(loaded), .err(err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    bit run      = 1'b0;
    int n_wea = 0, n_wea_p = 0, n_err = 0, n_loaded = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    endtask

    // ---------------- frame-level model ----------------
    int         m_n = 0;      // bytes of current frame received (0: no frame)
    bit         m_fin = 1'b0; // frame complete, completion cycle pending
    logic [7:0] m_cmd, m_addr, m_len, m_sum;
    logic       e_wea_p = 0, e_wea = 0, e_loaded = 0, e_err = 0;
    logic [7:0] e_wa_p, e_wd_p, e_wa, e_wd;
    logic [7:0] e_p = 0, e_pl = 0, e_b = 0, e_bl = 0;

    function automatic logic model_ready();
        if (m_fin) return 1'b0;
        if (m_n == 0) return ~lock;
        return 1'b1;
    endfunction

    task automatic model_step();
        int k;
        logic acc;
        if (reset) begin
            m_n = 0; m_fin = 0;
            e_wea_p = 0; e_wea = 0; e_loaded = 0; e_err = 0;
            e_p = 0; e_pl = 0; e_b = 0; e_bl = 0;
            return;
        end
        acc = in_valid && model_ready();
        e_wea_p = 0; e_wea = 0; e_loaded = 0; e_err = 0;
        if (m_fin) begin
            m_fin = 0;
            e_loaded = 1;
            if (m_cmd == 8'h50) begin e_p = m_addr; e_pl = m_len; end
            else begin e_b = m_addr; e_bl = m_len; end
        end else if (acc) begin
            if (m_n == 0) begin
                if (in_byte == 8'h50 || in_byte == 8'h42) begin
                    m_cmd = in_byte; m_n = 1; m_sum = 0;
                end else e_err = 1;
            end else if (m_n == 1) begin
                m_addr = in_byte; m_n = 2;
            end else if (m_n == 2) begin
                if (in_byte == 8'd0) begin e_err = 1; m_n = 0; end
                else begin m_len = in_byte; m_n = 3; end
            end else begin
                k = m_n - 3;
                if (k < int'(m_len)) begin
                    if (m_cmd == 8'h50) begin
                        e_wea_p = 1; e_wa_p = 8'(int'(m_addr) + k); e_wd_p = in_byte;
                    end else begin
                        e_wea = 1; e_wa = 8'(int'(m_addr) + k); e_wd = in_byte;
                    end
                    m_sum = m_sum ^ in_byte;
                    m_n++;
`ifndef LOADER_CSUM_EN
                    if (k + 1 == int'(m_len)) begin m_n = 0; m_fin = 1; end
`endif
                end else begin
                    m_n = 0;
                    if (in_byte == m_sum) m_fin = 1;
                    else e_err = 1;
                end
            end
        end
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    // per-cycle comparison against the model, plus strobe counters
    initial forever begin
        @(negedge clk);
        if (run) begin
            chk("in_ready", in_ready, model_ready());
            chk("busy", busy, (m_n != 0) || m_fin);
            chk("loaded", loaded, e_loaded);
            chk("err", err, e_err);
            chk("wea_p", wea_p, e_wea_p);
            chk("wea", wea, e_wea);
            chk("p", p, e_p);
            chk("pl", pl, e_pl);
            chk("b", b, e_b);
            chk("bl", bl, e_bl);
            if (e_wea_p) begin
                chk("addra_p", addra_p, e_wa_p);
                chk("dina_p", dina_p, e_wd_p);
            end
            if (e_wea) begin
                chk("addra", addra, e_wa);
                chk("dina", dina, e_wd);
            end
            n_wea   += int'(wea);
            n_wea_p += int'(wea_p);
            n_err   += int'(err);
            n_loaded += int'(loaded);
        end
    end

    // ---------------- drivers ----------------
    task automatic send(input logic [7:0] v);
        int  t = 0;
        logic ok;
        in_byte  = v;
        in_valid = 1'b1;
        forever begin
            @(negedge clk);
            ok = in_ready;
            @(posedge clk);
            #1;
            if (ok) break;
            t++;
            if (t > 20) begin
                n_checks++;
                $display("FAIL send_timeout: byte %0h not accepted within 20 cycles", v);
                break;
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    int s_wea, s_wea_p, s_err, s_loaded;

    task automatic snap();
        s_wea = n_wea; s_wea_p = n_wea_p; s_err = n_err; s_loaded = n_loaded;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        run = 1'b1;
        @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_strobes", {wea_p, wea, loaded, err}, 0);
        chk("rst_desc", {p, pl, b, bl}, 0);
        chk("rst_addr", {addra_p, dina_p, addra, dina}, 0);
        @(posedge clk);
        #1;

        // pattern frame 50 0A 02 41 42 with latency pinned by hand
        snap();
        send(8'h50); send(8'h0A); send(8'h02); send(8'h41);
        @(negedge clk);
        chk("f1_w0", {wea_p, addra_p, dina_p}, {1'b1, 8'h0A, 8'h41});
        @(posedge clk); #1;
        send(8'h42);
        @(negedge clk);
        chk("f1_w1", {wea_p, addra_p, dina_p, loaded}, {1'b1, 8'h0B, 8'h42, 1'b0});
        @(negedge clk);
        chk("f1_loaded", loaded, 1);
        chk("f1_desc", {p, pl}, {8'd10, 8'd2});
        @(posedge clk); #1;
        chk("f1_no_wea", n_wea - s_wea, 0);

        // block frame 42 91 1E + 30 bytes, valid toggling
        snap();
        send(8'h42); idle(1); send(8'h91); idle(1); send(8'h1E); idle(1);
        for (int i = 0; i < 30; i++) begin
            send(8'(i));
            idle(1);
        end
        idle(2);
        chk("f2_writes", n_wea - s_wea, 30);
        chk("f2_no_wea_p", n_wea_p - s_wea_p, 0);
        chk("f2_desc", {b, bl, p, pl}, {8'd145, 8'd30, 8'd10, 8'd2});

        // wrap frame, lock raised mid-frame must not stall it
        snap();
        send(8'h42); send(8'hFE); lock = 1'b1; send(8'h03);
        send(8'hAA); send(8'hBB); send(8'hCC);
        lock = 1'b0;
        idle(3);
        chk("f3_writes", n_wea - s_wea, 3);
        chk("f3_desc", {b, bl}, {8'd254, 8'd3});

        // bad command and zero length
        snap();
        send(8'h7E); send(8'h50); send(8'h0A); send(8'h00);
        idle(3);
        chk("f4_errs", n_err - s_err, 2);
        chk("f4_no_writes", (n_wea - s_wea) + (n_wea_p - s_wea_p), 0);
        chk("f4_desc", {p, pl}, {8'd10, 8'd2});

        // lock holds a frame start
        snap();
        lock = 1'b1; in_byte = 8'h50; in_valid = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("lock_ready", in_ready, 0);
        end
        @(posedge clk); #1;
        lock = 1'b0;
        send(8'h50); send(8'h30); send(8'h01);
`ifdef LOADER_CSUM_EN
        send(8'h55); send(8'h55);
`else
        send(8'h55);
`endif
        idle(3);
        chk("lock_desc", {p, pl}, {8'h30, 8'd1});
        chk("lock_loaded", n_loaded - s_loaded, 1);

        // reset mid-frame
        snap();
        send(8'h50); send(8'h20); send(8'h04); send(8'h01); send(8'h02);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        chk("mid_rst", {busy, loaded, err, p, pl}, 0);
        idle(3);
        chk("mid_rst_pulses", (n_loaded - s_loaded) + (n_err - s_err), 0);

`ifdef LOADER_CSUM_EN
        snap();
        send(8'h50); send(8'h00); send(8'h02); send(8'h0F); send(8'hF0); send(8'hFF);
        idle(3);
        chk("cs_ok_loaded", n_loaded - s_loaded, 1);
        chk("cs_ok_desc", {p, pl}, {8'd0, 8'd2});
        snap();
        send(8'h50); send(8'h07); send(8'h02); send(8'h0F); send(8'hF0); send(8'h00);
        idle(3);
        chk("cs_bad_err", n_err - s_err, 1);
        chk("cs_bad_desc", {p, pl}, {8'd0, 8'd2});
`endif

        run = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/psa_loader.md
Name: psa_loader

Overview:
- Byte-stream writer that fills the PSA pattern BRAM and search-block BRAM ahead of a search, from a host byte source such as a UART receiver.
- It is the write side of the memories the search engine reads.
- Publishes the address/length descriptors the search engine consumes: p, pl, b, bl.
- Sits between the host byte receiver and the two BRAM write ports (port A).

Parameters:
- CMD_PAT, 8'h50, command byte selecting the pattern BRAM ('P').
- CMD_BLK, 8'h42, command byte selecting the block BRAM ('B').

Ports:
- CLK100MHZ  in  1  system clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high reset.
- in_byte  in  8  host stream data.
- in_valid  in  1  in_byte valid.
- in_ready  out  1  loader accepts in_byte this cycle.
- lock  in  1  search in progress; no new frame may start.
- wea_p  out  1  pattern BRAM write enable.
- addra_p  out  8  pattern BRAM write address.
- dina_p  out  8  pattern BRAM write data.
- wea  out  1  block BRAM write enable.
- addra  out  8  block BRAM write address.
- dina  out  8  block BRAM write data.
- p  out  8  pattern start address from the last good 'P' frame.
- pl  out  8  pattern length from the last good 'P' frame.
- b  out  8  block start address from the last good 'B' frame.
- bl  out  8  block length from the last good 'B' frame.
- busy  out  1  frame in progress (state != IDLE).
- loaded  out  1  one-cycle pulse: frame completed OK.
- err  out  1  one-cycle pulse: frame rejected.

Behaviour:
- Frame format: CMD, ADDR, LEN, then LEN data bytes; plus CSUM when LOADER_CSUM_EN is defined.
- A byte is accepted only when in_valid && in_ready on a clock edge.
- FSM states: IDLE, ADDR, LEN, DATA, CSUM (macro only), FIN.
- IDLE: in_ready = !lock.
  - Byte equal to CMD_PAT or CMD_BLK: latch target, go to ADDR.
  - Any other byte: consumed, err pulses next cycle, stay IDLE.
- ADDR: latch start address and write pointer, go to LEN.
- LEN:
  - LEN = 0: err pulses, return to IDLE.
  - Otherwise: latch count, go to DATA.
- DATA:
  - Each accepted byte writes to the selected BRAM only; the other wea stays 0.
  - Write is registered: byte accepted at edge N gives wea/addra/dina (or the _p set) valid for the cycle after N, for exactly one cycle.
  - Pointer increments mod 256, so 8'hFF wraps to 8'h00. Descriptors store the raw start address; wrap is the search engine's concern.
  - On the LEN-th byte go to FIN (or CSUM when the macro is defined).
- FIN: in_ready = 0 for this one cycle.
  - loaded pulses.
  - Descriptor pair for the target updates with {start, LEN}: p/pl for 'P', b/bl for 'B'. Registers are visible the same cycle loaded is high.
  - Return to IDLE.
  - Latency: last data byte accepted at edge N, its write strobe in cycle N+1, loaded in cycle N+2.
- in_ready is 1 in ADDR, LEN, DATA and CSUM regardless of lock. lock only blocks frame start.
- in_valid low: no state change, no write strobe.
- Reset: all outputs 0, FSM to IDLE, descriptors cleared to 0.
- Reset mid-frame aborts the frame: no loaded, no err. Bytes already written stay in the BRAM.
- loaded and err are never high together. Neither is high outside its defined cycle.

Optional Feature:
- Macro LOADER_CSUM_EN.
- Defined:
  - An 8-bit XOR accumulator clears at CMD and XORs every data byte.
  - After the last data byte, FSM enters CSUM and accepts one byte.
  - Match: go to FIN (loaded, descriptors update).
  - Mismatch: err pulses, descriptors keep their old values, return to IDLE. Data already written is not rolled back.
- Not defined: no CSUM state; DATA goes straight to FIN and there is no accumulator logic.

Test Plan:
- After reset, stream 50 0A 02 41 42:
  - wea_p pulses at addra_p 10 with dina_p 41, then at 11 with 42.
  - loaded pulses 2 cycles after 42 is accepted; p = 10, pl = 2; wea never high.
- Stream 42 91 1E then 30 bytes 00..1D with in_valid toggling every other cycle:
  - 30 block writes at addra 145..174, stalling correctly on invalid cycles.
  - b = 145, bl = 30.
- Stream 42 FE 03 AA BB CC:
  - writes at addra FE, FF, 00 (wrap).
  - b = 254, bl = 3.
- Stream 7E, then 50 0A 00:
  - err pulses twice.
  - No write strobes; p and pl unchanged.
- lock = 1, present 50: in_ready = 0 and the byte is held. Drop lock: frame proceeds normally.
- Assert reset after the 2nd data byte of a 4-byte 'P' frame: no loaded, no err, busy = 0, p = pl = 0.
- With LOADER_CSUM_EN: stream 50 00 02 0F F0 FF → loaded. Same frame with checksum 00 → err, pl unchanged.
